vga_board_capture: RTL and testbench



---
 rtl/vga_board_capture.sv | 204 ++++++++++++++++++++
 tb/tb_vga_board_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_board_capture.sv
// Rebuilds the 8x8 Game of Life board from a VGA stream by sampling the centre
// pixel of every cell, publishing one board snapshot per complete frame.
module vga_board_capture #(
    parameter int BIT_WIDTH       = 3,
    parameter int BIT_HEIGHT      = 3,
    parameter int CELL_SIZE       = 50,
    parameter int H_BACK          = 48,
    parameter int V_BACK          = 33,
    parameter int H_TOTAL         = 800,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         hsync_in,
    input  logic                                         vsync_in,
    input  logic [1:0]                                   r_in,
    input  logic [1:0]                                   g_in,
    input  logic [1:0]                                   b_in,
    output logic [(1 << (BIT_WIDTH + BIT_HEIGHT)) - 1:0] board,
    output logic                                         board_valid,
    output logic                                         frame_error,
    output logic                                         locked
);
    localparam int BOARD_W = 1 << BIT_WIDTH;
    localparam int BOARD_H = 1 << BIT_HEIGHT;
    localparam int CELLS   = 1 << (BIT_WIDTH + BIT_HEIGHT);
    localparam int X0      = (H_ACTIVE - BOARD_W * CELL_SIZE) / 2;
    localparam int Y0      = (V_ACTIVE - BOARD_H * CELL_SIZE) / 2;
    localparam logic [5:0] RGB_ALIVE = 6'b10_00_10;
    localparam logic [5:0] RGB_DEAD  = 6'b11_10_11;
    localparam logic [9:0] X_SAT     = 10'd1023;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SEEK     = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_PUBLISH  = 2'd3
    } state_t;

    // Returns {recognised, alive} for a sampled colour.
    function automatic logic [1:0] classify(input logic [5:0] rgb);
        case (rgb)
            RGB_ALIVE: classify = 2'b11;
            RGB_DEAD:  classify = 2'b10;
            default:   classify = 2'b00;
        endcase
    endfunction

    logic                    r_hs;
    logic                    r_vs;
    logic [5:0]              r_rgb;
    logic [9:0]              r_x_cnt;
    logic [9:0]              r_y_cnt;
    state_t                  r_state;
    logic [CELLS-1:0]        r_shadow;
    logic                    r_err_acc;
    logic [CELLS-1:0]        r_board;
    logic                    r_valid;
    logic                    r_ferr;
    logic                    r_locked;

    logic                    w_hs_level;
    logic                    w_vs_level;
    logic                    w_hs_edge;
    logic                    w_vs_edge;
    logic [9:0]              w_hpos;
    logic [9:0]              w_vpos;
    logic                    w_col_hit;
    logic                    w_row_hit;
    logic [BIT_WIDTH-1:0]    w_col;
    logic [BIT_HEIGHT-1:0]   w_row;
    logic [1:0]              w_class;
    logic                    w_sample;
    logic                    w_publish;

    // Sync levels normalised so that 1 means deasserted.
    assign w_hs_level = (SYNC_ACTIVE_LOW != 0) ? hsync_in : ~hsync_in;
    assign w_vs_level = (SYNC_ACTIVE_LOW != 0) ? vsync_in : ~vsync_in;
    // Edges are taken as the deasserted level enters the input register, so the
    // counters always describe the pixel currently held in r_rgb.
    assign w_hs_edge  = w_hs_level & ~r_hs;
    assign w_vs_edge  = w_vs_level & ~r_vs;

    assign w_hpos    = (r_x_cnt >= 10'(H_BACK)) ? (r_x_cnt - 10'(H_BACK))
                                                : (r_x_cnt + 10'(H_TOTAL - H_BACK));
    assign w_vpos    = r_y_cnt - 10'(V_BACK);
    assign w_class   = classify(r_rgb);
    assign w_sample  = w_col_hit & w_row_hit;
    assign w_publish = (w_vpos == 10'(V_ACTIVE)) && (w_hpos == 10'd0);

    // Locate the cell whose centre pixel is being presented, if any.
    always_comb begin
        w_col_hit = 1'b0;
        w_col     = '0;
        w_row_hit = 1'b0;
        w_row     = '0;
        for (int c = 0; c < BOARD_W; c++) begin
            w_col_hit = w_col_hit | (w_hpos == 10'(X0 + c * CELL_SIZE + CELL_SIZE / 2));
            w_col     = (w_hpos == 10'(X0 + c * CELL_SIZE + CELL_SIZE / 2)) ? BIT_WIDTH'(c) : w_col;
        end
        for (int r = 0; r < BOARD_H; r++) begin
            w_row_hit = w_row_hit | (w_vpos == 10'(Y0 + r * CELL_SIZE + CELL_SIZE / 2));
            w_row     = (w_vpos == 10'(Y0 + r * CELL_SIZE + CELL_SIZE / 2)) ? BIT_HEIGHT'(r) : w_row;
        end
    end

    // Input stage: one register on every VGA input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_rgb <= 6'd0;
        end else begin
            r_hs  <= w_hs_level;
            r_vs  <= w_vs_level;
            r_rgb <= {r_in, g_in, b_in};
        end
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_cnt <= 10'd0;
            r_y_cnt <= 10'd0;
        end else begin
            if (w_hs_edge) begin
                r_x_cnt <= 10'd0;
            end else if (r_x_cnt != X_SAT) begin
                r_x_cnt <= r_x_cnt + 10'd1;
            end
            if (w_vs_edge) begin
                r_y_cnt <= 10'd0;
            end else if (r_x_cnt == 10'(H_BACK - 1)) begin
                r_y_cnt <= r_y_cnt + 10'd1;
            end
        end
    end

    // Frame state machine with sampling, publishing and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_UNLOCKED;
            r_shadow  <= '0;
            r_err_acc <= 1'b0;
            r_board   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_x_cnt == X_SAT) begin
                // hsync has gone missing: drop lock without touching the board.
                r_state  <= ST_UNLOCKED;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_vs_edge) begin
                            r_state  <= ST_SEEK;
                            r_locked <= 1'b1;
                        end
                    end
                    ST_SEEK: begin
                        r_shadow  <= '0;
                        r_err_acc <= 1'b0;
                        if (w_vpos == 10'd0) begin
                            r_state <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_vs_edge) begin
                            r_state <= ST_SEEK;
                            r_ferr  <= 1'b1;
                        end else if (w_publish) begin
                            r_state <= ST_PUBLISH;
                            r_board <= r_shadow;
                            r_ferr  <= r_err_acc;
                            r_valid <= 1'b1;
                        end else if (w_sample) begin
                            r_shadow[{w_row, w_col}] <= w_class[0];
                            if (!w_class[1]) begin
                                r_err_acc <= 1'b1;
                            end
                        end
                    end
                    ST_PUBLISH: begin
                        r_state <= ST_SEEK;
                    end
                    default: begin
                        r_state  <= ST_UNLOCKED;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign board       = r_board;
    assign board_valid = r_valid;
    assign frame_error = r_ferr;
    assign locked      = r_locked;
endmodule

// File: tb/tb_vga_board_capture.sv
// Scoreboard bench for vga_board_capture on a reduced VGA geometry that keeps
// the 8x8 board but shrinks cells and blanking so whole frames stay short.
module tb_vga_board_capture;
    localparam int CS   = 4;
    localparam int HA   = 48;
    localparam int HFP  = 2;
    localparam int HSW  = 4;
    localparam int HBP  = 6;
    localparam int HT   = HA + HFP + HSW + HBP;
    localparam int VA   = 40;
    localparam int VFP  = 2;
    localparam int VSW  = 2;
    localparam int VBP  = 3;
    localparam int VT   = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int X0   = (HA - 8 * CS) / 2;
    localparam int Y0   = (VA - 8 * CS) / 2;
    localparam int HS0  = HA + HFP;
    localparam int HS1  = HS0 + HSW;
    localparam int VS0  = VA + VFP;
    localparam int VS1  = VS0 + VSW;
    localparam int KILL_LEN = 1100;
    localparam int RST_LEN  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs  = 1'b1;
    logic        vs  = 1'b1;
    logic [1:0]  r_c = 2'd0;
    logic [1:0]  g_c = 2'd0;
    logic [1:0]  b_c = 2'd0;
    logic [63:0] board;
    logic        valid;
    logic        ferr;
    logic        locked;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [63:0] brd;
        logic        err;
        int unsigned mark;
        int          fidx;
    } exp_t;
    exp_t q[$];

    logic [63:0] held_brd = 64'd0;
    logic        held_err = 1'b0;

    vga_board_capture #(
        .BIT_WIDTH(3), .BIT_HEIGHT(3), .CELL_SIZE(CS), .H_BACK(HBP), .V_BACK(VBP),
        .H_TOTAL(HT), .SYNC_ACTIVE_LOW(1), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .reset(rst), .hsync_in(hs), .vsync_in(vs),
        .r_in(r_c), .g_in(g_c), .b_in(b_c),
        .board(board), .board_valid(valid), .frame_error(ferr), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Centre pixels carry the true state; the rest of each cell carries the
    // opposite state so only an exactly placed sample reads the board correctly.
    function automatic logic [5:0] pix(input logic [63:0] brd, input int bad, input int h, input int v);
        int  col, row, idx;
        bit  centre;
        logic alive;
        if (h < X0 || h >= X0 + 8 * CS || v < Y0 || v >= Y0 + 8 * CS) return 6'b00_00_00;
        col    = (h - X0) / CS;
        row    = (v - Y0) / CS;
        idx    = row * 8 + col;
        centre = ((h - X0) % CS == CS / 2) && ((v - Y0) % CS == CS / 2);
        alive  = brd[idx];
        if (centre && idx == bad) return 6'b01_01_01;
        if (!centre) alive = ~alive;
        return alive ? 6'b10_00_10 : 6'b11_10_11;
    endfunction

    task automatic render(input logic [63:0] brd, input int bad, input int kill_line,
                          input int rst_line, input bit expect_pub, input int fidx);
        int   kill_left;
        bit   chk_lock;
        logic [63:0] exp_brd;
        kill_left = 0;
        chk_lock  = (kill_line >= 0) || (rst_line >= 0);
        exp_brd   = (bad >= 0) ? (brd & ~(64'd1 << bad)) : brd;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                @(negedge clk);
                if (v == rst_line && h == 0) rst = 1'b1;
                if (v == rst_line && h == RST_LEN) rst = 1'b0;
                if (v == rst_line && h == RST_LEN + 2) begin
                    check("rst_board", board, 64'd0);
                    check("rst_valid", {63'd0, valid}, 64'd0);
                    check("rst_ferr", {63'd0, ferr}, 64'd0);
                    check("rst_locked", {63'd0, locked}, 64'd0);
                end
                if (chk_lock && v == VS1 && h == 0) check("locked_before", {63'd0, locked}, 64'd0);
                if (chk_lock && v == VS1 && h == 1) check("locked_after", {63'd0, locked}, 64'd1);
                if (v == kill_line && h == 0) kill_left = KILL_LEN;
                hs = !(h >= HS0 && h < HS1) || (kill_left > 0);
                vs = !(v >= VS0 && v < VS1);
                {r_c, g_c, b_c} = pix(brd, bad, h, v);
                if (kill_left > 0) begin
                    kill_left--;
                    if (kill_left == 0) begin
                        check("loss_locked", {63'd0, locked}, 64'd0);
                        check("loss_board", board, held_brd);
                    end
                end
                if (expect_pub && v == VA && h == 0)
                    q.push_back('{exp_brd, (bad >= 0), cyc, fidx});
            end
        end
    endtask

    // Scoreboard monitor: pops one expectation per pulse, otherwise outputs must hold.
    initial begin
        exp_t        e;
        int unsigned last_cyc;
        int          last_fidx;
        last_cyc  = 0;
        last_fidx = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_brd = 64'd0;
                held_err = 1'b0;
            end else if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("pub_board", board, e.brd);
                    check("pub_ferr", {63'd0, ferr}, {63'd0, e.err});
                    check("pub_latency", 64'(cyc - e.mark), 64'd2);
                    if (last_fidx >= 0)
                        check("pub_gap", 64'(cyc - last_cyc), 64'((e.fidx - last_fidx) * FRAME));
                    last_cyc  = cyc;
                    last_fidx = e.fidx;
                    held_brd  = e.brd;
                    held_err  = e.err;
                end
            end else begin
                check("board_hold", board, held_brd);
                check("ferr_hold", {63'd0, ferr}, {63'd0, held_err});
            end
        end
    end

    initial begin
        logic [63:0] p [0:4];
        for (int i = 0; i < 5; i++) p[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        render(64'h56A8_8808_0609_0909, -1, -1, 15, 1'b0, 0);
        render(64'h56A8_8808_0609_0909, -1, -1, -1, 1'b1, 1);
        render(64'h0, -1, -1, -1, 1'b1, 2);
        render(64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1, 1'b1, 3);
        render(64'hFFFF_FFFF_FFFF_FFFF, 21, -1, -1, 1'b1, 4);
        render(p[0], -1, -1, -1, 1'b1, 5);
        render(p[1], -1, 10, -1, 1'b0, 6);
        render(p[2], -1, -1, -1, 1'b1, 7);
        render(p[3], -1, -1, 20, 1'b0, 8);
        render(p[4], -1, -1, -1, 1'b1, 9);
        repeat (10) @(negedge clk);
        check("pending_pubs", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
